// File: rtl/image_word_loader.sv
// image_word_loader: buffers a host-written binary image (WORD_W-bit words,
// NEXT edge strobe, FINISH marks the last word), pulses start_snn, then
// streams the image one HEIGHT-pixel column per cycle for N_FRAMES passes.
// Optional feature macro: IMG_CHECKSUM_EN adds a running XOR of the accepted
// words on output port checksum.

// One buffer word; cleared on reset and when an image run completes.
module image_word_loader_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // word storage: clear wins over write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end

endmodule

module image_word_loader #(
  parameter int WORD_W   = 32,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int N_FRAMES = 16,
  localparam int N_WORDS = (WIDTH*HEIGHT + WORD_W - 1) / WORD_W,
  localparam int CNT_W   = $clog2(N_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_in,
  input  logic              next,
  input  logic              finish,
  output logic [HEIGHT-1:0] pixels_out,
  output logic              pix_valid,
  output logic              start_snn,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count,
  output logic              err
`ifdef IMG_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam int IMG_BITS = WIDTH * HEIGHT;
  localparam int COL_W    = (WIDTH    > 1) ? $clog2(WIDTH)    : 1;
  localparam int FRM_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_START, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic               next_q;
  logic               we;
  logic [CNT_W-1:0]   wr_ptr_q;
  logic [COL_W-1:0]   col_q, col_sel;
  logic [FRM_W-1:0]   frame_q;
  logic               acc_wr;   // host word accepted into the buffer
  logic               drop;     // host word dropped (buffer full or busy)
  logic               last_col; // final column of final frame is on the output
  logic               clr_img;  // return to LOAD: wipe buffer and pointer

  logic [IMG_BITS-1:0]              img;
  logic [WIDTH-1:0][HEIGHT-1:0]     cols;

  // A held-high next writes only once: strobe on the rising edge only.
  assign we = next & ~next_q;

  // next edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_q <= 1'b0;
    else        next_q <= next;
  end

  // Buffer slots. Each slot keeps only the image bits it actually covers,
  // so bits beyond WIDTH*HEIGHT in the last word are never stored.
  for (genvar k = 0; k < N_WORDS; k++) begin : g_slot
    localparam int REM = IMG_BITS - k*WORD_W;
    localparam int SW  = (REM < WORD_W) ? REM : WORD_W;

    image_word_loader_slot #(.W(SW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_img),
      .we    (acc_wr && (wr_ptr_q == CNT_W'(k))),
      .d     (data_in[SW-1:0]),
      .q     (img[k*WORD_W +: SW])
    );
  end

  // Pixel (c,r) sits at img[c*HEIGHT + r], which is exactly the packed layout.
  assign cols = img;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // next-state and control strobes
  always_comb begin
    state_d  = state_q;
    acc_wr   = 1'b0;
    drop     = 1'b0;
    last_col = 1'b0;
    clr_img  = 1'b0;
    col_sel  = '0;
    case (state_q)
      S_LOAD: begin
        if (we) begin
          if (wr_ptr_q < CNT_W'(N_WORDS)) acc_wr = 1'b1;
          else                            drop   = 1'b1;
          if (finish) state_d = S_START;
        end
      end
      S_START: begin
        col_sel = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        drop = we;
        if (col_q != COL_W'(WIDTH-1)) col_sel = col_q + 1'b1;
        if (col_q == COL_W'(WIDTH-1) && frame_q == FRM_W'(N_FRAMES-1)) begin
          last_col = 1'b1;
          clr_img  = 1'b1;
          state_d  = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // write pointer: advances per accepted word, rewinds after a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wr_ptr_q <= '0;
    else if (clr_img) wr_ptr_q <= '0;
    else if (acc_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
  end

  // sticky error; only the first accepted word of a fresh image clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if (acc_wr && wr_ptr_q == '0)   err <= 1'b0;
    else if (drop)                       err <= 1'b1;
  end

  // column/frame counters: col_q names the column currently on pixels_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      frame_q <= '0;
    end else if (state_q == S_START) begin
      col_q   <= '0;
      frame_q <= '0;
    end else if (state_q == S_STREAM && !last_col) begin
      col_q <= col_sel;
      if (col_q == COL_W'(WIDTH-1)) frame_q <= frame_q + 1'b1;
    end
  end

  // registered column output; START preloads column 0 so it appears in the
  // first STREAM cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixels_out <= '0;
      pix_valid  <= 1'b0;
    end else if (state_q == S_START || (state_q == S_STREAM && !last_col)) begin
      pixels_out <= cols[col_sel];
      pix_valid  <= 1'b1;
    end else begin
      pixels_out <= '0;
      pix_valid  <= 1'b0;
    end
  end

  // done marks the first LOAD cycle after the final column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= last_col;
  end

  assign start_snn  = (state_q == S_START);
  assign busy       = (state_q != S_LOAD);
  assign word_count = wr_ptr_q;

`ifdef IMG_CHECKSUM_EN
  // XOR of accepted words; dropped words never reach it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       checksum <= '0;
    else if (clr_img) checksum <= '0;
    else if (acc_wr)  checksum <= checksum ^ data_in;
  end
`endif

endmodule

// File: tb/tb_image_word_loader.sv
// Bench for image_word_loader: randomized host traffic checked every cycle
// against a transaction-level model (accepted words, cycles since the finish
// edge), plus literal expectations at key points.
module tb_image_word_loader;

  localparam int WORD_W   = 32;
  localparam int WIDTH    = 28;
  localparam int HEIGHT   = 28;
  localparam int N_FRAMES = 16;
  localparam int N_WORDS  = (WIDTH*HEIGHT + WORD_W - 1) / WORD_W;
  localparam int CNT_W    = $clog2(N_WORDS + 1);
  localparam int RUN      = WIDTH * N_FRAMES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WORD_W-1:0] data_in = '0;
  logic              next = 1'b0;
  logic              finish = 1'b0;
  logic [HEIGHT-1:0] pixels_out;
  logic              pix_valid, start_snn, done, busy, err;
  logic [CNT_W-1:0]  word_count;
`ifdef IMG_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
`endif

  image_word_loader #(
    .WORD_W(WORD_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .N_FRAMES(N_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .next       (next),
    .finish     (finish),
    .pixels_out (pixels_out),
    .pix_valid  (pix_valid),
    .start_snn  (start_snn),
    .done       (done),
    .busy       (busy),
    .word_count (word_count),
    .err        (err)
`ifdef IMG_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_run  = 0;   // image captured, start/stream in progress
  int                m_k    = 0;   // cycles since the finish edge (1 = start cycle)
  bit                m_done = 0;
  int                m_wc   = 0;
  bit                m_err  = 0;
  bit                m_prev = 0;
  logic [WORD_W-1:0] m_words [N_WORDS];
  logic [WORD_W-1:0] m_csum = '0;

  function automatic logic [HEIGHT-1:0] mcol(int c);
    logic [HEIGHT-1:0] v;
    int idx;
    v = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      idx  = c*HEIGHT + r;
      v[r] = m_words[idx / WORD_W][idx % WORD_W];
    end
    return v;
  endfunction

  task automatic m_clear();
    m_wc   = 0;
    m_csum = '0;
    for (int i = 0; i < N_WORDS; i++) m_words[i] = '0;
  endtask

  initial begin
    bit w_e;
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_k = 0; m_done = 0; m_err = 0; m_prev = 0;
        m_clear();
      end else begin
        w_e    = next && !m_prev;
        m_prev = next;
        m_done = 0;
        if (!m_run) begin
          if (w_e) begin
            if (m_wc < N_WORDS) begin
              if (m_wc == 0) m_err = 0;
              m_words[m_wc] = data_in;
              m_csum ^= data_in;
              m_wc++;
            end else begin
              m_err = 1;
            end
            if (finish) begin
              m_run = 1;
              m_k   = 1;
            end
          end
        end else begin
          if (w_e) m_err = 1;
          m_k++;
          if (m_k == 2 + RUN) begin
            m_run  = 0;
            m_done = 1;
            m_clear();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [HEIGHT-1:0] e_pix;
    forever begin
      @(negedge clk);
      #1;
      e_pix = (m_run && m_k >= 2) ? mcol((m_k - 2) % WIDTH) : '0;
      check("start_snn",  start_snn,  m_run && m_k == 1);
      check("busy",       busy,       m_run);
      check("pix_valid",  pix_valid,  m_run && m_k >= 2);
      check("pixels_out", pixels_out, e_pix);
      check("done",       done,       m_done);
      check("word_count", word_count, m_wc);
      check("err",        err,        m_err);
`ifdef IMG_CHECKSUM_EN
      check("checksum",   checksum,   m_csum);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns at the falling edge of the cycle right after the write edge.
  task automatic put_word(logic [WORD_W-1:0] d, bit fin, int hold = 1);
    @(negedge clk);
    data_in = d;
    finish  = fin;
    next    = 1'b1;
    repeat (hold) @(negedge clk);
    next    = 1'b0;
    finish  = 1'b0;
    data_in = $urandom;
  endtask

  // Idle cycles with noise on finish/data_in while next stays low.
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      finish  = $urandom_range(0, 1);
      data_in = $urandom;
    end
    finish = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit seen = 0;
    for (int i = 0; i < RUN + 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({name, " done seen"}, seen, 1);
    check({name, " word_count after done"}, word_count, 0);
    check({name, " pix_valid after done"}, pix_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit seen;
    // reset state
    repeat (2) @(negedge clk);
    check("reset pixels_out", pixels_out, 0);
    check("reset busy",       busy,       0);
    check("reset word_count", word_count, 0);
    check("reset err",        err,        0);
    #2 rst_n = 1'b1;

    // reset in the middle of a stream
    put_word($urandom, 0);
    put_word($urandom, 0);
    put_word($urandom, 1);
    repeat (50) @(negedge clk);
    check("mid-stream pix_valid", pix_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort pixels_out", pixels_out, 0);
    check("abort pix_valid",  pix_valid,  0);
    check("abort busy",       busy,       0);
    check("abort word_count", word_count, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < RUN + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || start_snn === 1'b1) seen = 1;
    end
    check("no done/start after abort", seen, 0);
    put_word($urandom, 1);
    wait_done("one-word image");

    // full image of 0xAAAAAAAA: every column has the odd rows set
    for (int i = 0; i < N_WORDS - 1; i++) put_word(32'hAAAA_AAAA, 0);
    put_word(32'hAAAA_AAAA, 1);
    check("full start_snn", start_snn, 1);
    check("full word_count", word_count, N_WORDS);
    @(negedge clk);
    check("full col0", pixels_out, 28'hAAAAAAA);
    @(negedge clk);
    check("full col1", pixels_out, 28'hAAAAAAA);
    wait_done("full image");

    // held-high next writes once
    @(negedge clk);
    data_in = 32'h0000_0001;
    finish  = 1'b1;
    next    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) check("held start_snn", start_snn, 1);
      if (i == 2) check("held col0", pixels_out, 28'h0000001);
      if (i == 3) check("held col1", pixels_out, 28'h0000000);
    end
    check("held word_count", word_count, 1);
    check("held err", err, 0);
    next = 1'b0;
    finish = 1'b0;
    wait_done("held next");

    // overflow: 26th word dropped, finish on a dropped word still starts
    for (int i = 0; i < N_WORDS; i++) put_word($urandom, 0);
    check("ovf no err before", err, 0);
    put_word($urandom, 0);
    check("ovf err", err, 1);
    check("ovf word_count", word_count, N_WORDS);
    put_word($urandom, 1);
    check("ovf start_snn", start_snn, 1);
    check("ovf err kept", err, 1);
    wait_done("overflow");
    check("err sticky after run", err, 1);
    put_word($urandom, 0);
    check("err cleared by new image", err, 0);
    put_word($urandom, 1);
    wait_done("after overflow");

    // short image of two all-ones words
    put_word(32'hFFFF_FFFF, 0);
    put_word(32'hFFFF_FFFF, 1);
    @(negedge clk);
    check("short col0", pixels_out, 28'hFFFFFFF);
    @(negedge clk);
    check("short col1", pixels_out, 28'hFFFFFFF);
    @(negedge clk);
    check("short col2", pixels_out, 28'h00000FF);
    @(negedge clk);
    check("short col3", pixels_out, 28'h0000000);
    wait_done("short image");

    // writes during the stream are dropped
    put_word(32'h1234_5678, 0);
    put_word(32'h0F0F_0F0F, 1);
    repeat (5) @(negedge clk);
    put_word($urandom, 0);
    check("stream write err", err, 1);
`ifdef IMG_CHECKSUM_EN
    check("checksum literal", checksum, 32'h1D3B_5977);
`endif
    put_word($urandom, 1, 3);
    check("stream word_count", word_count, 2);
    wait_done("stream writes");

    // randomized images
    for (int img = 0; img < 5; img++) begin
      int n;
      n = $urandom_range(1, N_WORDS);
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 3));
        put_word($urandom, i == n - 1, $urandom_range(1, 3));
      end
      wait_done("random image");
    end

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
